core_seq: RTL

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/core_seq.sv
// rtl/core_seq.sv - attention core instruction sequencer: Q/K load, MAC, execute, drain, ofifo read, accumulate, divide.
module core_seq #(
    parameter int bw    = 8,
    parameter int pr    = 8,
    parameter int len   = 8,
    parameter int drain = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [pr*bw-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [18:0]      inst,
    output logic [pr*bw-1:0] mem_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       phase
);

    typedef enum logic [3:0] {
        s_idle  = 4'd0,
        s_qload = 4'd1,
        s_kload = 4'd2,
        s_kmac  = 4'd3,
        s_qexe  = 4'd4,
        s_drain = 4'd5,
        s_ofrd  = 4'd6,
        s_acc   = 4'd7,
        s_div   = 4'd8,
        s_done  = 4'd9
    } state_t;

    localparam int b_sfp_div  = 18;
    localparam int b_sfp_acc  = 17;
    localparam int b_ofifo_rd = 16;
    localparam int b_execute  = 7;
    localparam int b_load     = 6;
    localparam int b_qmem_rd  = 5;
    localparam int b_qmem_wr  = 4;
    localparam int b_kmem_rd  = 3;
    localparam int b_kmem_wr  = 2;
    localparam int b_pmem_rd  = 1;
    localparam int b_pmem_wr  = 0;

    localparam logic [4:0] len_last   = 5'(len - 1);
    localparam logic [4:0] len_cnt    = 5'(len);
    localparam logic [4:0] div_last   = 5'(2 * len - 1);
    localparam logic [4:0] drain_last = 5'(drain - 1);
    // A zero drain skips the DRAIN state entirely.
    localparam state_t after_qexe = (drain == 0) ? s_ofrd : s_drain;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [18:0]       inst_q, inst_d;
    logic [pr*bw-1:0]  mem_in_q, mem_in_d;
    logic              done_q, done_d;
    logic [4:0]        cnt_m1;

    assign cnt_m1 = cnt_q - 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= s_idle;
            cnt_q    <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inst_q   <= inst_d;
            mem_in_q <= mem_in_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inst_d     = '0;
        mem_in_d   = mem_in_q;
        done_d     = 1'b0;
        data_ready = 1'b0;
        case (state_q)
            s_idle: begin
                if (start) begin
                    state_d = s_qload;
                    cnt_d   = '0;
                end
            end
            s_qload, s_kload: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    inst_d[15:12] = cnt_q[3:0];
                    if (state_q == s_qload) inst_d[b_qmem_wr] = 1'b1;
                    else                    inst_d[b_kmem_wr] = 1'b1;
                    mem_in_d = data_in;
                    if (cnt_q == len_last) begin
                        state_d = (state_q == s_qload) ? s_kload : s_kmac;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            s_kmac, s_qexe: begin
                // Read row c while the array consumes the row read one cycle earlier.
                if (cnt_q < len_cnt) begin
                    inst_d[15:12] = cnt_q[3:0];
                    if (state_q == s_kmac) inst_d[b_kmem_rd] = 1'b1;
                    else                   inst_d[b_qmem_rd] = 1'b1;
                end
                if (cnt_q != 5'd0) begin
                    if (state_q == s_kmac) inst_d[b_load]    = 1'b1;
                    else                   inst_d[b_execute] = 1'b1;
                end
                if (cnt_q == len_cnt) begin
                    state_d = (state_q == s_kmac) ? s_qexe : after_qexe;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            s_drain: begin
                if (cnt_q == drain_last) begin
                    state_d = s_ofrd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            s_ofrd: begin
                if (cnt_q < len_cnt) inst_d[b_ofifo_rd] = 1'b1;
                if (cnt_q != 5'd0) begin
                    inst_d[b_pmem_wr] = 1'b1;
                    inst_d[11:8]      = cnt_m1[3:0];
                end
                if (cnt_q == len_cnt) begin
                    state_d = s_acc;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            s_acc: begin
                if (cnt_q < len_cnt) begin
                    inst_d[b_pmem_rd] = 1'b1;
                    inst_d[11:8]      = cnt_q[3:0];
                end
                if (cnt_q != 5'd0) inst_d[b_sfp_acc] = 1'b1;
                if (cnt_q == len_cnt) begin
                    state_d = s_div;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            s_div: begin
                // Even count reads row cnt/2, odd count writes the divided result back.
                inst_d[11:8] = cnt_q[4:1];
                if (cnt_q[0]) begin
                    inst_d[b_sfp_div] = 1'b1;
                    inst_d[b_pmem_wr] = 1'b1;
                end else begin
                    inst_d[b_pmem_rd] = 1'b1;
                end
                if (cnt_q == div_last) begin
                    state_d = s_done;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            s_done: begin
                done_d  = 1'b1;
                state_d = s_idle;
                cnt_d   = '0;
            end
            default: begin
                state_d = s_idle;
                cnt_d   = '0;
            end
        endcase
    end

    assign inst   = inst_q;
    assign mem_in = mem_in_q;
    assign done   = done_q;
    assign busy   = (state_q != s_idle);
    assign phase  = state_q;

endmodule
